moving_avg: RTL and testbench

MOVING_AVG -- requirements
Module: moving_avg

---
 rtl/moving_avg.sv | 164 ++++++++++++++++
 tb/tb_moving_avg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/moving_avg.sv
// moving_avg -- stereo moving-average filter over a window of 2^LOG2_TAPS
// samples per channel, with a raw-sample bypass.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   valid    new-sample strobe, level held high for several clk cycles
//   lft_in   signed left sample, stable while valid is high
//   rht_in   signed right sample, stable while valid is high
//   en       1 = output the moving average, 0 = output the raw sample
//   lft_out  registered signed left result
//   rht_out  registered signed right result
//   out_vld  single-clk pulse marking a new lft_out/rht_out pair
//
// Each sample event is handled in three steps: capture (IDLE),
// buffer/sum update (ACCUM), output register load (OUTP). Events seen
// while busy are dropped, not queued.
module moving_avg #(
  parameter int LOG2_TAPS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic signed [15:0] lft_in,
  input  logic signed [15:0] rht_in,
  input  logic               en,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rht_out,
  output logic               out_vld
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = 16 + LOG2_TAPS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUTP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                    valid_q;
  logic                    sample_evt;
  logic                    do_capture;
  logic                    do_accum;
  logic                    do_output;

  logic signed [15:0]      new_l, new_r;
  logic signed [15:0]      buf_l [TAPS];
  logic signed [15:0]      buf_r [TAPS];
  logic [LOG2_TAPS-1:0]    wr_ptr;
  logic signed [SW-1:0]    sum_l, sum_r;
  logic signed [SW-1:0]    new_l_ext, new_r_ext;
  logic signed [SW-1:0]    old_l_ext, old_r_ext;

  // Rising edge of the level-type strobe; a long high produces one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid;
    end
  end

  assign sample_evt = valid & ~valid_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and step strobes
  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    do_accum   = 1'b0;
    do_output  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_evt) begin
          do_capture = 1'b1;
          state_nxt  = ACCUM;
        end
      end
      ACCUM: begin
        do_accum  = 1'b1;
        state_nxt = OUTP;
      end
      OUTP: begin
        do_output = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_l <= '0;
      new_r <= '0;
    end else if (do_capture) begin
      new_l <= lft_in;
      new_r <= rht_in;
    end
  end

  // Sign extension of the incoming and outgoing samples to sum width
  always_comb begin
    new_l_ext = {{LOG2_TAPS{new_l[15]}}, new_l};
    new_r_ext = {{LOG2_TAPS{new_r[15]}}, new_r};
    old_l_ext = {{LOG2_TAPS{buf_l[wr_ptr][15]}}, buf_l[wr_ptr]};
    old_r_ext = {{LOG2_TAPS{buf_r[wr_ptr][15]}}, buf_r[wr_ptr]};
  end

  // Circular history and running sums. The entry at wr_ptr is always the
  // oldest sample, so swapping it out keeps the sum exact over the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        buf_l[i] <= '0;
        buf_r[i] <= '0;
      end
      wr_ptr <= '0;
      sum_l  <= '0;
      sum_r  <= '0;
    end else if (do_accum) begin
      sum_l         <= sum_l + new_l_ext - old_l_ext;
      sum_r         <= sum_r + new_r_ext - old_r_ext;
      buf_l[wr_ptr] <= new_l;
      buf_r[wr_ptr] <= new_r;
      wr_ptr        <= wr_ptr + 1'b1;
    end
  end

  // Output registers; the slice of the signed sum is a floor division
  // by TAPS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_out <= '0;
      rht_out <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= do_output;
      if (do_output) begin
        if (en) begin
          lft_out <= sum_l[15+LOG2_TAPS:LOG2_TAPS];
          rht_out <= sum_r[15+LOG2_TAPS:LOG2_TAPS];
        end else begin
          lft_out <= new_l;
          rht_out <= new_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_moving_avg.sv
// Self-checking bench for moving_avg with a scoreboard of expected outputs.
module tb_moving_avg;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid;
  logic signed [15:0] lft_in, rht_in;
  logic               en;
  logic signed [15:0] lft_out, rht_out;
  logic               out_vld;

  moving_avg #(.LOG2_TAPS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .en      (en),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .out_vld (out_vld)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pulses = 0;
  int pushes = 0;
  int vld_cyc = 0;
  logic prev_vld = 1'b0;
  logic [15:0] last_l = '0, last_r = '0;

  logic [31:0] exp_q [$];   // {left, right}
  int hist_l [$];
  int hist_r [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    hist_l.delete();
    hist_r.delete();
    for (int i = 0; i < 16; i++) begin
      hist_l.push_back(0);
      hist_r.push_back(0);
    end
    exp_q.delete();
  endtask

  // Advance the reference window and push the expected output pair.
  task automatic model_push(input logic signed [15:0] l, input logic signed [15:0] r,
                            input logic e);
    int sl, sr;
    logic [15:0] el, er;
    void'(hist_l.pop_front());
    void'(hist_r.pop_front());
    hist_l.push_back(int'(l));
    hist_r.push_back(int'(r));
    sl = 0;
    sr = 0;
    foreach (hist_l[i]) sl += hist_l[i];
    foreach (hist_r[i]) sr += hist_r[i];
    if (e) begin
      el = 16'(sl >>> 4);
      er = 16'(sr >>> 4);
    end else begin
      el = l;
      er = r;
    end
    exp_q.push_back({el, er});
    pushes++;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic e,
                      input int hold);
    @(negedge clk);
    lft_in = l;
    rht_in = r;
    en     = e;
    valid  = 1'b1;
    model_push(l, r, e);
    repeat (hold) @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every out_vld pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_vld === 1'b1) begin
      logic [31:0] e;
      pulses++;
      vld_cyc = cyc;
      check("vld_width", {31'd0, prev_vld}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_vld", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("lft_out", {16'd0, lft_out}, {16'd0, e[31:16]});
        check("rht_out", {16'd0, rht_out}, {16'd0, e[15:0]});
      end
      last_l = lft_out;
      last_r = rht_out;
    end
    prev_vld = out_vld;
  end

  initial begin
    int rise_cyc, p0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    en     = 1'b1;
    lft_in = '0;
    rht_in = '0;
    model_reset();

    // Reset with random inputs: outputs must stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid  = 1'($urandom);
      lft_in = 16'($urandom);
      rht_in = 16'($urandom);
      en     = 1'($urandom);
      #1;
      check("rst_lft", {16'd0, lft_out}, 32'd0);
      check("rst_rht", {16'd0, rht_out}, 32'd0);
      check("rst_vld", {31'd0, out_vld}, 32'd0);
    end
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_vld_before_valid", pulses, 0);

    // Ramp up with en=1.
    for (int k = 1; k <= 16; k++) send(16'h0100, 16'hFF00, 1'b1, 2 + (k % 3));
    check("ramp_end_l", {16'd0, last_l}, 32'h0100);
    check("ramp_end_r", {16'd0, last_r}, 32'hFF00);

    // Wrap: zeros push the ramp out of the window.
    send(16'h0000, 16'h0000, 1'b1, 2);
    check("wrap_first_l", {16'd0, last_l}, 32'h00F0);
    for (int k = 0; k < 16; k++) send(16'h0000, 16'h0000, 1'b1, 1);
    check("wrap_zero_l", {16'd0, last_l}, 32'h0000);

    // Timing: long valid, second rise landing on the OUTP cycle.
    p0 = pulses;
    @(negedge clk);
    lft_in = 16'h0040;
    rht_in = 16'hFFC0;
    en     = 1'b1;
    valid  = 1'b1;
    rise_cyc = cyc;
    model_push(16'h0040, 16'hFFC0, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    repeat (15) @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    check("timing_pulses", pulses - p0, 1);
    check("timing_latency", vld_cyc - rise_cyc, 3);

    // Extremes.
    for (int k = 0; k < 16; k++) send(16'h7FFF, 16'h7FFF, 1'b1, 2);
    check("max_l", {16'd0, last_l}, 32'h7FFF);
    for (int k = 0; k < 16; k++) send(16'h8000, 16'h8000, 1'b1, 2);
    check("min_l", {16'd0, last_l}, 32'h8000);
    check("min_r", {16'd0, last_r}, 32'h8000);

    // Bypass, then averaging that includes bypassed samples.
    send(16'h1234, 16'hABCD, 1'b0, 3);
    check("bypass_l", {16'd0, last_l}, 32'h1234);
    for (int k = 0; k < 4; k++) send(16'($urandom), 16'($urandom), 1'b0, 2);
    for (int k = 0; k < 6; k++) send(16'($urandom), 16'($urandom), 1'b1, 2);

    // Reset mid-update, valid held high across release.
    @(negedge clk);
    lft_in = 16'h5555;
    rht_in = 16'h2222;
    en     = 1'b1;
    valid  = 1'b1;
    @(negedge clk);           // FSM now in ACCUM
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_vld", {31'd0, out_vld}, 32'd0);
    check("abort_lft", {16'd0, lft_out}, 32'd0);
    @(negedge clk);
    lft_in = 16'h0320;
    rht_in = 16'hFCE0;
    rst_n  = 1'b1;
    model_push(16'h0320, 16'hFCE0, 1'b1);
    repeat (3) @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_l", {16'd0, last_l}, 32'h0032);
    send(16'h0100, 16'h0100, 1'b1, 2);
    check("post_rst_next_l", {16'd0, last_l}, 32'h0042);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    check("pulse_count", pulses, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
